// File: rtl/boletim_urna.sv
// Ballot-box report transmitter.
// On a finish rising edge the three vote counters are snapshotted, the
// winner is decided, and a 5-byte UART-style frame (header, C1, C2, null,
// checksum) is shifted out on tx, LSB first, one start and one stop bit
// per byte, with no idle gap between bytes.
module boletim_urna #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       finish,
  input  logic [7:0] contadorC1,
  input  logic [7:0] contadorC2,
  input  logic [7:0] contadorNull,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic [1:0] winner
);

  localparam int unsigned DATA_W = 8;

  // FSM encoding kept as plain constants for compatibility with older tools.
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START_BIT = 3'd1;
  localparam logic [2:0] DATA_BITS = 3'd2;
  localparam logic [2:0] STOP_BIT  = 3'd3;
  localparam logic [2:0] DONE      = 3'd4;

  localparam logic [7:0] LAST_CLK  = 8'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_BIT  = 3'd7;
  localparam logic [2:0] LAST_BYTE = 3'd4;

  // Winner codes.
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_C1   = 2'b01;
  localparam logic [1:0] WIN_C2   = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // 8-bit modular sum: the carry out of the checksum is intentionally dropped.
  function automatic logic [DATA_W-1:0] checksum_wrap(
    input logic [DATA_W-1:0] h,
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [DATA_W-1:0] c
  );
    logic [DATA_W+1:0] sum;
    sum = {2'b00, h} + {2'b00, a} + {2'b00, b} + {2'b00, c};
    return sum[DATA_W-1:0];
  endfunction

  // Unsigned vote comparison; equal totals report a tie.
  function automatic logic [1:0] decide_winner(
    input logic [DATA_W-1:0] c1,
    input logic [DATA_W-1:0] c2
  );
    if (c1 > c2)      return WIN_C1;
    else if (c2 > c1) return WIN_C2;
    else              return WIN_TIE;
  endfunction

  logic [2:0]        state;
  logic [7:0]        clk_cnt;
  logic [2:0]        bit_idx;
  logic [2:0]        byte_idx;
  logic [DATA_W-1:0] snap_c1;
  logic [DATA_W-1:0] snap_c2;
  logic [DATA_W-1:0] snap_null;
  logic              finish_q;
  logic              armed;
  logic              win_pend;
  logic              start_evt;
  logic              bit_end;
  logic [DATA_W-1:0] cur_byte;
  logic [DATA_W-1:0] checksum;

  // A start needs a low sample of finish since reset (armed), so a finish
  // already high when reset is released cannot trigger a report.
  assign start_evt = finish & ~finish_q & armed & (state == IDLE);
  assign bit_end   = (clk_cnt == LAST_CLK);
  assign checksum  = checksum_wrap(HEADER, snap_c1, snap_c2, snap_null);

  // Select the byte currently being serialized.
  always_comb begin
    cur_byte = HEADER;
    case (byte_idx)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = snap_c1;
      3'd2:    cur_byte = snap_c2;
      3'd3:    cur_byte = snap_null;
      3'd4:    cur_byte = checksum;
      default: cur_byte = HEADER;
    endcase
  end

  // finish history for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      finish_q <= 1'b0;
      armed    <= 1'b0;
    end else begin
      finish_q <= finish;
      if (!finish) armed <= 1'b1;
    end
  end

  // Winner is resolved one cycle after start, from the snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_pend <= 1'b0;
      winner   <= WIN_NONE;
    end else begin
      win_pend <= start_evt;
      if (win_pend) winner <= decide_winner(snap_c1, snap_c2);
    end
  end

  // Frame sequencer; tx/busy/done are registered alongside the state so the
  // outputs change exactly with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_cnt   <= 8'd0;
      bit_idx   <= 3'd0;
      byte_idx  <= 3'd0;
      snap_c1   <= '0;
      snap_c2   <= '0;
      snap_null <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          done <= 1'b0;
          if (start_evt) begin
            snap_c1   <= contadorC1;
            snap_c2   <= contadorC2;
            snap_null <= contadorNull;
            state     <= START_BIT;
            clk_cnt   <= 8'd0;
            bit_idx   <= 3'd0;
            byte_idx  <= 3'd0;
            tx        <= 1'b0;
            busy      <= 1'b1;
          end
        end

        START_BIT: begin
          if (bit_end) begin
            clk_cnt <= 8'd0;
            bit_idx <= 3'd0;
            state   <= DATA_BITS;
            tx      <= cur_byte[0];
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end

        DATA_BITS: begin
          if (bit_end) begin
            clk_cnt <= 8'd0;
            if (bit_idx == LAST_BIT) begin
              state <= STOP_BIT;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end

        STOP_BIT: begin
          if (bit_end) begin
            clk_cnt <= 8'd0;
            if (byte_idx == LAST_BYTE) begin
              state <= DONE;
              tx    <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              state    <= START_BIT;
              tx       <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boletim_urna.sv
// Bench for boletim_urna: directed and random frames checked against a
// frame-level reference model (byte list -> expected serial bit per cycle).
module tb_boletim_urna;

  localparam int         CPB   = 4;
  localparam logic [7:0] HDR   = 8'hA5;
  localparam int         FRAME = 50 * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       finish;
  logic [7:0] c1, c2, cn;
  logic       tx, busy, done;
  logic [1:0] winner;

  int n_chk  = 0;
  int n_fail = 0;

  boletim_urna #(.CLKS_PER_BIT(CPB), .HEADER(HDR)) dut (
    .clk(clk), .rst_n(rst_n), .finish(finish),
    .contadorC1(c1), .contadorC2(c2), .contadorNull(cn),
    .tx(tx), .busy(busy), .done(done), .winner(winner)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: expected line level at frame cycle i for the given 5 bytes.
  function automatic logic model_bit(input logic [39:0] fr, input int i);
    int j, p;
    logic [7:0] byt;
    j   = i / (10 * CPB);
    p   = (i % (10 * CPB)) / CPB;
    byt = fr[8*j +: 8];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return byt[p-1];
  endfunction

  // Runs one report and checks every cycle of it plus the aftermath.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] n,
                           input bit hold, input bit disturb, input bit edge_at_done);
    logic [39:0] fr;
    logic [7:0]  ck;
    logic [1:0]  w;
    int          s, dones, extra_busy, extra_done, tail;
    s  = int'(HDR) + int'(a) + int'(b) + int'(n);
    ck = 8'(s % 256);
    w  = (a > b) ? 2'b01 : (b > a) ? 2'b10 : 2'b11;
    fr = {ck, n, b, a, HDR};
    dones = 0;
    c1 = a; c2 = b; cn = n;
    @(negedge clk);
    finish = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk($sformatf("tx[%0d]", i), tx, model_bit(fr, i));
      chk($sformatf("busy[%0d]", i), busy, 1'b1);
      if (done) dones++;
      if (i == 1) chk("winner_early", winner, w);
      if (i == 2 && !hold) finish = 1'b0;
      if (disturb) begin
        if (i == 20) begin c1 = 8'($urandom); c2 = 8'($urandom); cn = 8'($urandom); end
        if (i == 100) finish = 1'b0;
        if (i == 101) finish = 1'b1;
        if (i == 103 && !hold) finish = 1'b0;
      end
    end
    chk("done_in_frame", dones, 0);
    @(negedge clk);
    chk("done_pulse", done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("tx_at_done", tx, 1'b1);
    chk("winner", winner, w);
    if (edge_at_done) finish = 1'b1;
    @(negedge clk);
    chk("done_width", done, 1'b0);
    extra_busy = 0; extra_done = 0;
    tail = hold ? 300 : 20;
    for (int i = 0; i < tail; i++) begin
      @(negedge clk);
      if (busy) extra_busy++;
      if (done) extra_done++;
    end
    chk("no_second_frame_busy", extra_busy, 0);
    chk("no_second_frame_done", extra_done, 0);
    chk("winner_holds", winner, w);
    finish = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int bz, dn;
    rst_n = 1'b0; finish = 1'b0; c1 = 8'd0; c2 = 8'd0; cn = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_winner", winner, 2'b00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed frames.
    run_frame(8'd5, 8'd3, 8'd1, 1'b0, 1'b0, 1'b0);
    run_frame(8'd7, 8'd7, 8'd0, 1'b0, 1'b0, 1'b0);
    run_frame(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_frame(8'd2, 8'd9, 8'd4, 1'b0, 1'b0, 1'b0);
    // finish held high, inputs changed mid-frame.
    run_frame(8'd1, 8'd0, 8'd6, 1'b1, 1'b1, 1'b0);
    // Second finish edge mid-frame is ignored.
    run_frame(8'd3, 8'd8, 8'd2, 1'b0, 1'b1, 1'b0);
    // Rising edge during the DONE cycle is ignored.
    run_frame(8'd10, 8'd11, 8'd12, 1'b0, 1'b0, 1'b1);

    // Random frames.
    for (int k = 0; k < 4; k++)
      run_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);

    // Reset during the third byte aborts the frame immediately.
    c1 = 8'($urandom); c2 = 8'($urandom); cn = 8'($urandom);
    @(negedge clk);
    finish = 1'b1;
    @(negedge clk);
    finish = 1'b0;
    repeat (2 * 10 * CPB + 4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_winner", winner, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    bz = 0; dn = 0;
    for (int i = 0; i < FRAME + 20; i++) begin
      @(negedge clk);
      if (busy) bz++;
      if (done) dn++;
    end
    chk("abort_no_busy", bz, 0);
    chk("abort_no_done", dn, 0);
    run_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);

    // finish already high at reset release must not start a report.
    @(negedge clk);
    finish = 1'b1;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bz = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) bz++;
    end
    chk("high_at_release_no_start", bz, 0);
    finish = 1'b0;
    @(negedge clk);
    run_frame(8'($urandom), 8'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
